mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Request arbiter and sequencer in front of the byte-serial memory controller. Shares the single memory port between instruction fetch (IF) and the load/store buffer (LSB). It latches one request at a time, issues it to the controller with a valid/ready handshake, waits for completion, and returns a one-cycle response to the owner. It also applies starvation protection, IO-store backpressure and fetch flush.

## Interface
- ADDR_W, 32, request address width
- DATA_W, 32, request/response data width
- STARVE_MAX, 4, number of consecutive LSB grants while IF waits before IF is forced through
- clk_in  input  1  clock; all logic on rising edge
- rst_in  input  1  reset: one clock; reset is synchronous and active-low
- rdy_in  input  1  global enable; low freezes all state and outputs
- if_req_valid  input  1  IF request, held high until if_resp_valid
- if_req_addr  input  ADDR_W  fetch address (4-byte read)
- if_resp_valid  output  1  one-cycle fetch completion pulse
- if_resp_data  output  DATA_W  fetched instruction
- flush  input  1  mispredict; kills any in-flight IF request
- lsb_req_valid  input  1  LSB request, held high until lsb_resp_valid
- lsb_req_wr  input  1  1 = store, 0 = load
- lsb_req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as word
- lsb_req_addr  input  ADDR_W  access address
- lsb_req_wdata  input  DATA_W  store data, low bytes significant
- lsb_resp_valid  output  1  one-cycle completion pulse (loads and stores)
- lsb_resp_data  output  DATA_W  load data, zero-extended to size; 0 for stores
- io_buffer_full  input  1  UART output buffer full
- mc_req_valid  output  1  request to memory controller
- mc_req_ready  input  1  controller accepts request
- mc_req_wr  output  1  write enable
- mc_req_len  output  3  byte count: 1, 2 or 4
- mc_req_addr  output  ADDR_W  latched address
- mc_req_wdata  output  DATA_W  latched store data
- mc_done  input  1  transaction complete pulse
- mc_rdata  input  DATA_W  read data, valid with mc_done

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, at least one valid request:
  - Pick the winner.
  - Latch addr, wr, len and wdata into owner registers.
  - Go to ISSUE.
- Default priority: LSB over IF.
- Starvation guard:
  - starve_cnt (3 bits, saturating) increments on each LSB grant while if_req_valid is high.
  - It clears on any IF grant, or when if_req_valid is low in IDLE.
  - When starve_cnt reaches STARVE_MAX, IF wins.
- ISSUE: mc_req_valid = 1, except when the request is an IO store (wr=1 and addr[17:16]==2'b11) and io_buffer_full=1; then mc_req_valid = 0.
  - Go to WAIT on mc_req_valid && mc_req_ready.
- WAIT: on mc_done, capture mc_rdata masked to len (bytes above len zeroed) and go to RESP.
- RESP: pulse the owner's resp_valid for one cycle, then go to IDLE. No grant is made in RESP, so the owner's still-high valid is never re-granted.
- Flush, when the owner is IF:
  - In ISSUE before handshake: return to IDLE next cycle; mc_req_valid drops.
  - In WAIT: set a discard flag, finish the transaction, suppress if_resp_valid in RESP.
- Flush in IDLE or RESP with an LSB owner: no effect. Flush never affects LSB transactions.
- IF requests present in the same cycle as flush are not granted.

## Timing
- Reset (rst_in=0 at an edge):
  - State goes to IDLE; starve_cnt and the discard flag clear.
  - All outputs go to 0: resp_valid, resp_data, mc_req_* and mc_req_len included.
  - Reset mid-transaction abandons it; the controller is reset by the same signal.
- Request sampled high in IDLE at edge T: mc_req_valid is high from T+1.
- Handshake at edge H: WAIT from H+1; mc_req_valid is low from H+1.
- mc_done at edge D: resp_valid is high for cycle D+1 only. IDLE at D+2; next mc_req_valid earliest at D+3.
- Minimum turnaround with a zero-wait controller: 4 cycles per request.
- rdy_in=0: no state, counter or output changes. A resp_valid pulse in progress is held until rdy_in returns high.
- mc_req_addr, mc_req_wr, mc_req_len and mc_req_wdata are stable from ISSUE through WAIT.

## Configuration
- MEM_ARB_STARVE_GUARD_EN defined: starvation guard active as described above.
- MEM_ARB_STARVE_GUARD_EN undefined: strict LSB-over-IF priority; starve_cnt logic is removed; STARVE_MAX is ignored.

## Test plan
- Single IF fetch at addr 0x0000_1000, controller returns 0x00C0_0093 after 4 cycles -> one mc request with len=4, wr=0; if_resp_data=0x00C0_0093 for one cycle; no LSB pulse.
- IF and LSB load (size=0, addr 0x20, mc_rdata=0xFFFF_FF80) both valid in IDLE -> LSB granted first, lsb_resp_data=0x0000_0080; IF granted in the next IDLE.
- LSB valid continuously with IF waiting, STARVE_MAX=4, guard enabled -> after 4 LSB grants the 5th grant goes to IF; with the macro undefined, IF is never granted while LSB is valid.
- Store to 0x0003_0000 with io_buffer_full=1 for 10 cycles -> mc_req_valid stays low for those 10 cycles, then rises; lsb_resp_valid fires after mc_done; resp_data=0.
- Flush while an IF request is in WAIT -> mc_done consumed, no if_resp_valid; the next IF request (new PC) is granted normally.
- rst_in=0 during WAIT, then rdy_in toggled low for 3 cycles mid-request -> all outputs are 0 after reset; during rdy_in low, state and mc_req_* are frozen.

Source files
------------

// File: rtl/mem_req_arbiter_if.sv
// Memory-controller request port shared by the arbiter (master) and the
// byte-serial memory controller (slave).
interface mem_req_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mc_req_valid;
  logic              mc_req_ready;
  logic              mc_req_wr;
  logic [2:0]        mc_req_len;
  logic [ADDR_W-1:0] mc_req_addr;
  logic [DATA_W-1:0] mc_req_wdata;
  logic              mc_done;
  logic [DATA_W-1:0] mc_rdata;

  modport master (
    output mc_req_valid, mc_req_wr, mc_req_len, mc_req_addr, mc_req_wdata,
    input  mc_req_ready, mc_done, mc_rdata
  );

  modport slave (
    input  mc_req_valid, mc_req_wr, mc_req_len, mc_req_addr, mc_req_wdata,
    output mc_req_ready, mc_done, mc_rdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// IF / LSB request arbiter and sequencer in front of the memory controller.
// Define MEM_ARB_STARVE_GUARD_EN to enable the IF starvation guard.
module mem_req_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,

  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_resp_valid,
  output logic [DATA_W-1:0] if_resp_data,
  input  logic              flush,

  input  logic              lsb_req_valid,
  input  logic              lsb_req_wr,
  input  logic [1:0]        lsb_req_size,
  input  logic [ADDR_W-1:0] lsb_req_addr,
  input  logic [DATA_W-1:0] lsb_req_wdata,
  output logic              lsb_resp_valid,
  output logic [DATA_W-1:0] lsb_resp_data,

  input  logic              io_buffer_full,

  mem_req_arbiter_if.master mc
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic       {OWN_IF, OWN_LSB}                  owner_t;

  localparam int NBYTES = DATA_W / 8;

  state_t            state, state_n;
  owner_t            owner, owner_n;
  logic              discard_q, discard_n;
  logic              wr_q;
  logic [2:0]        len_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              load, capture;
  logic              grant_if, grant_lsb, if_force;
  logic              flush_if, io_block, handshake;
  logic [2:0]        lsb_len;
  logic [DATA_W-1:0] rdata_masked;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    case (lsb_req_size)
      2'd0:    lsb_len = 3'd1;
      2'd1:    lsb_len = 3'd2;
      default: lsb_len = 3'd4;
    endcase
  end

  // A fetch seen together with flush belongs to the mispredicted path.
  assign grant_if  = if_req_valid && !flush && (!lsb_req_valid || if_force);
  assign grant_lsb = lsb_req_valid && !grant_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  assign if_force = (int'(starve_cnt) >= STARVE_MAX);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      starve_cnt <= 3'd0;
    end else if (rdy_in && state == S_IDLE) begin
      if (grant_if || !if_req_valid) begin
        starve_cnt <= 3'd0;
      end else if (grant_lsb && starve_cnt != 3'd7) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end
`else
  // Strict LSB-over-IF priority; the starvation limit has no meaning here.
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign if_force          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Request / response sequencing
  // ---------------------------------------------------------------------------
  assign flush_if  = flush && (owner == OWN_IF);
  assign io_block  = wr_q && (addr_q[17:16] == 2'b11) && io_buffer_full;
  assign handshake = mc.mc_req_valid && mc.mc_req_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_n   = state;
    owner_n   = owner;
    discard_n = discard_q;
    load      = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_if || grant_lsb) begin
          state_n   = S_ISSUE;
          owner_n   = grant_if ? OWN_IF : OWN_LSB;
          discard_n = 1'b0;
          load      = 1'b1;
        end
      end
      S_ISSUE: begin
        // Once the controller has taken the request it must run to completion.
        if (handshake) begin
          state_n   = S_WAIT;
          discard_n = flush_if;
        end else if (flush_if) begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush_if) discard_n = 1'b1;
        if (mc.mc_done) begin
          state_n = S_RESP;
          capture = 1'b1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    // NOTE: reset is synchronous (sampled on the clock edge) and state uses non-blocking assignments.
    if (!rst_in) begin
      state     <= S_IDLE;
      owner     <= OWN_IF;
      discard_q <= 1'b0;
    end else if (rdy_in) begin
      state     <= state_n;
      owner     <= owner_n;
      discard_q <= discard_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Request latches and read-data capture
  // ---------------------------------------------------------------------------
  always_comb begin
    rdata_masked = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (i < int'(len_q)) rdata_masked[i*8 +: 8] = mc.mc_rdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_q    <= 1'b0;
      len_q   <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (rdy_in) begin
      if (load) begin
        wr_q    <= grant_lsb ? lsb_req_wr    : 1'b0;
        len_q   <= grant_lsb ? lsb_len       : 3'd4;
        addr_q  <= grant_lsb ? lsb_req_addr  : if_req_addr;
        wdata_q <= grant_lsb ? lsb_req_wdata : '0;
      end
      // Stores report zero data.
      if (capture) rdata_q <= wr_q ? '0 : rdata_masked;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mc.mc_req_valid = (state == S_ISSUE) && !io_block;
  assign mc.mc_req_wr    = wr_q;
  assign mc.mc_req_len   = len_q;
  assign mc.mc_req_addr  = addr_q;
  assign mc.mc_req_wdata = wdata_q;

  assign if_resp_valid  = (state == S_RESP) && (owner == OWN_IF) && !discard_q;
  assign if_resp_data   = if_resp_valid ? rdata_q : '0;
  assign lsb_resp_valid = (state == S_RESP) && (owner == OWN_LSB);
  assign lsb_resp_data  = lsb_resp_valid ? rdata_q : '0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter; the bench plays the
// memory controller and both requesters.
module tb_mem_req_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        flush;
  logic        lsb_req_valid;
  logic        lsb_req_wr;
  logic [1:0]  lsb_req_size;
  logic [31:0] lsb_req_addr;
  logic [31:0] lsb_req_wdata;
  logic        lsb_resp_valid;
  logic [31:0] lsb_resp_data;
  logic        io_buffer_full;

  int n_total = 0;
  int n_bad   = 0;

  mem_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mc ();

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .if_req_valid   (if_req_valid),
    .if_req_addr    (if_req_addr),
    .if_resp_valid  (if_resp_valid),
    .if_resp_data   (if_resp_data),
    .flush          (flush),
    .lsb_req_valid  (lsb_req_valid),
    .lsb_req_wr     (lsb_req_wr),
    .lsb_req_size   (lsb_req_size),
    .lsb_req_addr   (lsb_req_addr),
    .lsb_req_wdata  (lsb_req_wdata),
    .lsb_resp_valid (lsb_resp_valid),
    .lsb_resp_data  (lsb_resp_data),
    .io_buffer_full (io_buffer_full),
    .mc             (mc)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Accept the pending request, stay busy wait_cycles, then pulse mc_done.
  // Returns one cycle after the done edge, i.e. in the response cycle.
  task automatic run_mc(input int wait_cycles, input logic [31:0] rdata);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (mc.mc_req_valid) seen = 1'b1;
      else step();
    end
    check("mc_valid_seen", 32'(seen), 32'd1);
    if (seen) begin
      mc.mc_req_ready = 1'b1;
      step();
      mc.mc_req_ready = 1'b0;
      check("mc_valid_drop_after_hs", 32'(mc.mc_req_valid), 32'd0);
      repeat (wait_cycles) step();
      mc.mc_rdata = rdata;
      mc.mc_done  = 1'b1;
      step();
      mc.mc_done  = 1'b0;
    end
  endtask

  task automatic lsb_set(input logic wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    lsb_req_valid = 1'b1;
    lsb_req_wr    = wr;
    lsb_req_size  = size;
    lsb_req_addr  = addr;
    lsb_req_wdata = wdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  sz_tab   [3];
    logic [31:0] rd_tab   [3];
    logic [31:0] len_tab  [3];
    logic [31:0] exp_tab  [3];
    logic [31:0] exp_addr;

    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    if_req_valid = 1'b0; if_req_addr = '0;
    lsb_req_valid = 1'b0; lsb_req_wr = 1'b0; lsb_req_size = '0;
    lsb_req_addr = '0; lsb_req_wdata = '0;
    mc.mc_req_ready = 1'b0; mc.mc_done = 1'b0; mc.mc_rdata = '0;

    // Reset state
    step(); step();
    rst_in = 1'b1;
    check("rst_mc_valid", 32'(mc.mc_req_valid), 32'd0);
    check("rst_mc_len",   32'(mc.mc_req_len),   32'd0);
    check("rst_mc_addr",  mc.mc_req_addr,       32'd0);
    check("rst_if_resp",  32'(if_resp_valid),   32'd0);
    check("rst_lsb_resp", 32'(lsb_resp_valid),  32'd0);

    // Single IF fetch
    if_req_valid = 1'b1; if_req_addr = 32'h0000_1000;
    step();
    check("if_mc_valid", 32'(mc.mc_req_valid), 32'd1);
    check("if_mc_len",   32'(mc.mc_req_len),   32'd4);
    check("if_mc_wr",    32'(mc.mc_req_wr),    32'd0);
    check("if_mc_addr",  mc.mc_req_addr,       32'h0000_1000);
    run_mc(3, 32'h00C0_0093);
    check("if_resp_valid", 32'(if_resp_valid),  32'd1);
    check("if_resp_data",  if_resp_data,        32'h00C0_0093);
    check("if_no_lsb",     32'(lsb_resp_valid), 32'd0);
    if_req_valid = 1'b0;
    step();
    check("if_resp_one_cycle", 32'(if_resp_valid), 32'd0);

    // IF and LSB byte load together: LSB first, then IF
    if_req_valid = 1'b1; if_req_addr = 32'h0000_1004;
    lsb_set(1'b0, 2'd0, 32'h20, 32'h0);
    step();
    check("prio_lsb_addr", mc.mc_req_addr, 32'h20);
    check("prio_lsb_len",  32'(mc.mc_req_len), 32'd1);
    run_mc(1, 32'hFFFF_FF80);
    check("prio_lsb_resp", 32'(lsb_resp_valid), 32'd1);
    check("prio_lsb_data", lsb_resp_data, 32'h0000_0080);
    check("prio_if_quiet", 32'(if_resp_valid), 32'd0);
    lsb_req_valid = 1'b0;
    step();
    step();
    check("prio_if_addr", mc.mc_req_addr, 32'h0000_1004);
    run_mc(0, 32'h1111_2222);
    check("prio_if_data", if_resp_data, 32'h1111_2222);
    if_req_valid = 1'b0;
    step();

    // Load size table: half, illegal size 3 (word), byte
    sz_tab  = '{2'd1, 2'd3, 2'd0};
    rd_tab  = '{32'hABCD_1234, 32'hCAFE_F00D, 32'h1234_56A5};
    len_tab = '{32'd2, 32'd4, 32'd1};
    exp_tab = '{32'h0000_1234, 32'hCAFE_F00D, 32'h0000_00A5};
    for (int k = 0; k < 3; k++) begin
      lsb_set(1'b0, sz_tab[k], 32'h24 + 32'(k), 32'h0);
      step();
      check($sformatf("size%0d_len", k), 32'(mc.mc_req_len), len_tab[k]);
      run_mc(0, rd_tab[k]);
      check($sformatf("size%0d_data", k), lsb_resp_data, exp_tab[k]);
      lsb_req_valid = 1'b0;
      step();
    end

    // Starvation: LSB valid continuously, IF waiting
    if_req_valid = 1'b1; if_req_addr = 32'h0000_2000;
    lsb_set(1'b0, 2'd2, 32'h40, 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_addr = (k == 4) ? 32'h0000_2000 : 32'h40;
`else
      exp_addr = 32'h40;
`endif
      check($sformatf("starve_grant%0d", k), mc.mc_req_addr, exp_addr);
      run_mc(0, 32'(k));
      step();
    end
    if_req_valid = 1'b0; lsb_req_valid = 1'b0;
    step();

    // IO store held back by a full UART buffer
    io_buffer_full = 1'b1;
    lsb_set(1'b1, 2'd2, 32'h0003_0000, 32'hCAFE_0055);
    step();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("io_block_c%0d", k), 32'(mc.mc_req_valid), 32'd0);
      step();
    end
    io_buffer_full = 1'b0;
    #1;
    check("io_release_valid", 32'(mc.mc_req_valid), 32'd1);
    check("io_store_wr",      32'(mc.mc_req_wr),    32'd1);
    check("io_store_wdata",   mc.mc_req_wdata,      32'hCAFE_0055);
    run_mc(2, 32'hDEAD_BEEF);
    check("io_store_resp",      32'(lsb_resp_valid), 32'd1);
    check("io_store_resp_data", lsb_resp_data,       32'd0);
    lsb_req_valid = 1'b0;
    step();

    // Non-IO store is not held back
    io_buffer_full = 1'b1;
    lsb_set(1'b1, 2'd2, 32'h0002_0000, 32'h5);
    step();
    check("nonio_store_valid", 32'(mc.mc_req_valid), 32'd1);
    run_mc(0, 32'h0);
    check("nonio_store_resp", 32'(lsb_resp_valid), 32'd1);
    lsb_req_valid = 1'b0; io_buffer_full = 1'b0;
    step();

    // Flush while IF is in WAIT
    if_req_valid = 1'b1; if_req_addr = 32'h0000_3000;
    step();
    mc.mc_req_ready = 1'b1;
    step();
    mc.mc_req_ready = 1'b0;
    flush = 1'b1; if_req_valid = 1'b0;
    step();
    flush = 1'b0;
    step();
    mc.mc_rdata = 32'h55; mc.mc_done = 1'b1;
    step();
    mc.mc_done = 1'b0;
    check("flush_wait_no_resp", 32'(if_resp_valid), 32'd0);
    check("flush_wait_no_data", if_resp_data,       32'd0);
    step();
    if_req_valid = 1'b1; if_req_addr = 32'h0000_4000;
    step();
    check("flush_new_pc", mc.mc_req_addr, 32'h0000_4000);
    run_mc(0, 32'h0000_0013);
    check("flush_new_resp", 32'(if_resp_valid), 32'd1);
    check("flush_new_data", if_resp_data,       32'h0000_0013);
    if_req_valid = 1'b0;
    step();

    // Flush while IF is in ISSUE, then an IF request coincident with flush
    if_req_valid = 1'b1; if_req_addr = 32'h0000_5000;
    step();
    check("flush_issue_pre", 32'(mc.mc_req_valid), 32'd1);
    flush = 1'b1; if_req_valid = 1'b0;
    step();
    check("flush_issue_drop", 32'(mc.mc_req_valid), 32'd0);
    if_req_valid = 1'b1; if_req_addr = 32'h0000_6000;
    step();
    check("flush_same_cycle_nogrant", 32'(mc.mc_req_valid), 32'd0);
    flush = 1'b0; if_req_valid = 1'b0;
    step();

    // Flush has no effect on an LSB transaction
    lsb_set(1'b0, 2'd2, 32'h60, 32'h0);
    step();
    flush = 1'b1;
    step();
    check("flush_lsb_keep", 32'(mc.mc_req_valid), 32'd1);
    flush = 1'b0;
    run_mc(0, 32'h0000_0077);
    check("flush_lsb_data", lsb_resp_data, 32'h0000_0077);
    lsb_req_valid = 1'b0;
    step();

    // Reset during WAIT
    lsb_set(1'b1, 2'd2, 32'h80, 32'h99);
    step();
    mc.mc_req_ready = 1'b1;
    step();
    mc.mc_req_ready = 1'b0;
    rst_in = 1'b0;
    step();
    check("rstw_mc_valid", 32'(mc.mc_req_valid), 32'd0);
    check("rstw_mc_len",   32'(mc.mc_req_len),   32'd0);
    check("rstw_mc_addr",  mc.mc_req_addr,       32'd0);
    check("rstw_mc_wr",    32'(mc.mc_req_wr),    32'd0);
    check("rstw_mc_wdata", mc.mc_req_wdata,      32'd0);
    check("rstw_lsb_resp", 32'(lsb_resp_valid),  32'd0);
    rst_in = 1'b1; lsb_req_valid = 1'b0;
    step();

    // rdy_in low freezes ISSUE and holds a response pulse
    lsb_set(1'b1, 2'd1, 32'h100, 32'hBEEF);
    step();
    check("rdy_issue_len", 32'(mc.mc_req_len), 32'd2);
    rdy_in = 1'b0; mc.mc_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("rdy_frz_valid%0d", k), 32'(mc.mc_req_valid), 32'd1);
      check($sformatf("rdy_frz_addr%0d", k),  mc.mc_req_addr,        32'h100);
    end
    rdy_in = 1'b1;
    step();
    mc.mc_req_ready = 1'b0;
    check("rdy_hs_after", 32'(mc.mc_req_valid), 32'd0);
    mc.mc_done = 1'b1;
    step();
    mc.mc_done = 1'b0;
    check("rdy_resp", 32'(lsb_resp_valid), 32'd1);
    rdy_in = 1'b0;
    step(); step();
    check("rdy_resp_held", 32'(lsb_resp_valid), 32'd1);
    rdy_in = 1'b1; lsb_req_valid = 1'b0;
    step();
    check("rdy_resp_end", 32'(lsb_resp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
